// File: rtl/fifo_pkg.sv
// Shared constants and types for the 16-entry audio sample FIFO
// (write-pointer, read-pointer and status stages).
package fifo_pkg;

  localparam int ADDR_W       = 4;
  localparam int DEPTH        = 2 ** ADDR_W;
  localparam int PTR_W        = ADDR_W + 1;
  localparam int DEF_AF_LEVEL = 12;
  localparam int DEF_AE_LEVEL = 4;

  // Pointers carry one wrap bit above the address bits.
  typedef logic [PTR_W-1:0] ptr_t;
  // Level spans 0..DEPTH, so it needs the same width as a pointer.
  typedef logic [PTR_W-1:0] level_t;

  typedef enum logic [1:0] {
    LVL_HOLD,
    LVL_INC,
    LVL_DEC
  } lvl_op_t;

  // A simultaneous accepted write and read leave the level unchanged.
  function automatic lvl_op_t level_op(input logic we_q, input logic rd_q);
    if (we_q && !rd_q) return LVL_INC;
    if (rd_q && !we_q) return LVL_DEC;
    return LVL_HOLD;
  endfunction

endpackage

// File: rtl/fifo_status_if.sv
// Request/status bundle between the FIFO status stage and its neighbours.
// With FIFO_PTR_CHECK_EN defined the bundle also carries ptr_mismatch.
interface fifo_status_if;
  import fifo_pkg::*;

  logic   wr;
  logic   rd;
  ptr_t   wptr;
  ptr_t   rptr;
  logic   clr_err;
  logic   fifo_we;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_almost_full;
  logic   fifo_almost_empty;
  level_t fifo_level;
  logic   fifo_overflow;
  logic   fifo_underflow;
`ifdef FIFO_PTR_CHECK_EN
  logic   ptr_mismatch;
`endif

  // Producer/consumer side: drives requests and pointers, observes status.
  modport master (
    output wr, rd, wptr, rptr, clr_err,
`ifdef FIFO_PTR_CHECK_EN
    input  ptr_mismatch,
`endif
    input  fifo_we, fifo_full, fifo_empty, fifo_almost_full,
           fifo_almost_empty, fifo_level, fifo_overflow, fifo_underflow
  );

  // Status stage side.
  modport slave (
    input  wr, rd, wptr, rptr, clr_err,
`ifdef FIFO_PTR_CHECK_EN
    output ptr_mismatch,
`endif
    output fifo_we, fifo_full, fifo_empty, fifo_almost_full,
           fifo_almost_empty, fifo_level, fifo_overflow, fifo_underflow
  );

endinterface

// File: rtl/fifo_status.sv
// Flag and occupancy stage for the 16-entry audio sample FIFO.
// Qualifies raw requests, tracks the level and registers all flags from the
// next level so they never lag it. Optional macro FIFO_PTR_CHECK_EN adds a
// sticky ptr_mismatch cross-check of (wptr - rptr) against the level.
module fifo_status
  import fifo_pkg::*;
#(
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input logic          clk,
  input logic          rst,
  fifo_status_if.slave bus
);

  localparam level_t FULL_LVL = level_t'(DEPTH);
  localparam level_t AF_LVL   = level_t'(AF_LEVEL);
  localparam level_t AE_LVL   = level_t'(AE_LEVEL);

  level_t level_r;
  level_t level_next;
  logic   full_r;
  logic   empty_r;
  logic   af_r;
  logic   ae_r;
  logic   overflow_r;
  logic   underflow_r;
  logic   we_q;
  logic   rd_q;

  assign we_q = bus.wr & ~full_r;
  assign rd_q = bus.rd & ~empty_r;

  // Next occupancy from the qualified requests; cannot wrap because the
  // qualification blocks writes at DEPTH and reads at zero.
  always_comb begin
    // NOTE: default first so every path assigns level_next and no latch forms.
    level_next = level_r;
    unique case (level_op(we_q, rd_q))
      LVL_INC: level_next = level_r + level_t'(1);
      LVL_DEC: level_next = level_r - level_t'(1);
      default: level_next = level_r;
    endcase
  end

  // Level, flags and sticky errors; reset wins over every other input.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      level_r     <= '0;
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
      af_r        <= 1'b0;
      ae_r        <= 1'b1;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      level_r     <= level_next;
      full_r      <= (level_next == FULL_LVL);
      empty_r     <= (level_next == '0);
      af_r        <= (level_next >= AF_LVL);
      ae_r        <= (level_next <= AE_LVL);
      // A new error event in the same cycle as clr_err keeps the flag set.
      overflow_r  <= (bus.wr & full_r)  | (overflow_r  & ~bus.clr_err);
      underflow_r <= (bus.rd & empty_r) | (underflow_r & ~bus.clr_err);
    end
  end

  assign bus.fifo_we           = we_q;
  assign bus.fifo_full         = full_r;
  assign bus.fifo_empty        = empty_r;
  assign bus.fifo_almost_full  = af_r;
  assign bus.fifo_almost_empty = ae_r;
  assign bus.fifo_level        = level_r;
  assign bus.fifo_overflow     = overflow_r;
  assign bus.fifo_underflow    = underflow_r;

`ifdef FIFO_PTR_CHECK_EN
  ptr_t ptr_diff;
  logic mismatch_r;

  // Modulo-2**PTR_W distance between the pointers equals the true occupancy.
  assign ptr_diff = bus.wptr - bus.rptr;

  // Sticky flag for a pointer stage that moved without a qualified enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_r <= 1'b0;
    end else begin
      mismatch_r <= (ptr_diff != level_r) | (mismatch_r & ~bus.clr_err);
    end
  end

  assign bus.ptr_mismatch = mismatch_r;
`else
  // Pointers are only consumed by the cross-check.
  logic unused_ptrs;
  assign unused_ptrs = ^{bus.wptr, bus.rptr};
`endif

endmodule

// File: tb/tb_fifo_status.sv
// Self-checking bench for fifo_status. A reference model pushes the expected
// registered state for every clocked step; a negedge monitor pops and
// compares it once the DUT has produced it. Scenario tasks add inline checks.
module tb_fifo_status;
  import fifo_pkg::*;

  typedef struct {
    int    due;
    int    level;
    bit    ovf;
    bit    unf;
    bit    mm;
    string name;
  } exp_t;

  logic clk;
  logic rst;
  int   cycle;
  int   n_checks;
  int   n_pass;
  exp_t sb[$];

  // Reference model state.
  int   m_level;
  bit   m_ovf;
  bit   m_unf;
  bit   m_mm;
  ptr_t m_wptr;
  ptr_t m_rptr;

  fifo_status_if bus();

  fifo_status dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [11:0] pack_exp(input exp_t e);
    logic [4:0] lv;
    lv = 5'(e.level);
    return {lv, e.level == 16, e.level == 0, e.level >= 12, e.level <= 4,
            e.ovf, e.unf, e.mm};
  endfunction

  function automatic logic [11:0] pack_obs();
    logic mm;
`ifdef FIFO_PTR_CHECK_EN
    mm = bus.ptr_mismatch;
`else
    mm = 1'b0;
`endif
    return {bus.fifo_level, bus.fifo_full, bus.fifo_empty, bus.fifo_almost_full,
            bus.fifo_almost_empty, bus.fifo_overflow, bus.fifo_underflow, mm};
  endfunction

  // Scoreboard monitor: compare every entry whose clock edge has passed.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cycle) begin
      exp_t e;
      logic [11:0] obs;
      logic [11:0] expv;
      e    = sb.pop_front();
      obs  = pack_obs();
      expv = pack_exp(e);
      n_checks++;
      if (obs !== expv)
        $display("FAIL sb_%s cycle %0d: got {lvl,full,empty,af,ae,ovf,unf,mm}=%b want %b",
                 e.name, cycle, obs, expv);
      else
        n_pass++;
    end
  end

  task automatic drive(input bit w, input bit r, input bit c);
    bus.wr      = w;
    bus.rd      = r;
    bus.clr_err = c;
    #1;
  endtask

  // Advance the model by one edge, push its expectation, then clock the DUT.
  task automatic tick(input string name);
    exp_t e;
    bit   full;
    bit   empty;
    bit   wq;
    bit   rq;
    ptr_t d;
    full  = (m_level == 16);
    empty = (m_level == 0);
    wq    = bus.wr && !full;
    rq    = bus.rd && !empty;
    if (rst) begin
      m_level = 0; m_ovf = 0; m_unf = 0; m_mm = 0; m_wptr = '0; m_rptr = '0;
    end else begin
      d       = m_wptr - m_rptr;
      m_mm    = (int'(d) != m_level) || (m_mm && !bus.clr_err);
      m_ovf   = (bus.wr && full)  || (m_ovf && !bus.clr_err);
      m_unf   = (bus.rd && empty) || (m_unf && !bus.clr_err);
      m_level = m_level + int'(wq) - int'(rq);
      if (wq) m_wptr = m_wptr + 1'b1;
      if (rq) m_rptr = m_rptr + 1'b1;
    end
`ifndef FIFO_PTR_CHECK_EN
    m_mm = 0;
`endif
    e.due = cycle + 1; e.level = m_level; e.ovf = m_ovf; e.unf = m_unf;
    e.mm = m_mm; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #2;
    bus.wptr = m_wptr;
    bus.rptr = m_rptr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0);
    tick("reset");
    tick("reset");
    rst = 1'b0;
    repeat (5) tick("idle");
    n_checks++;
    if ({bus.fifo_level, bus.fifo_empty, bus.fifo_almost_empty, bus.fifo_full,
         bus.fifo_overflow, bus.fifo_underflow} !== {5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_state: got lvl=%0d e=%b ae=%b f=%b ov=%b un=%b want 0 1 1 0 0 0",
               bus.fifo_level, bus.fifo_empty, bus.fifo_almost_empty, bus.fifo_full,
               bus.fifo_overflow, bus.fifo_underflow);
    else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0);
      n_checks++;
      if (bus.fifo_we !== 1'b1)
        $display("FAIL fill_we step %0d: got %b want 1", i, bus.fifo_we);
      else n_pass++;
      tick("fill");
      n_checks++;
      if (bus.fifo_almost_full !== logic'(i + 1 >= 12))
        $display("FAIL fill_af level %0d: got %b want %b", i + 1,
                 bus.fifo_almost_full, i + 1 >= 12);
      else n_pass++;
    end
    n_checks++;
    if (bus.fifo_full !== 1'b1 || bus.fifo_level !== 5'd16)
      $display("FAIL fill_full: got full=%b lvl=%0d want 1 16", bus.fifo_full, bus.fifo_level);
    else n_pass++;
    drive(1, 0, 0);
    n_checks++;
    if (bus.fifo_we !== 1'b0)
      $display("FAIL full_we_blocked: got %b want 0", bus.fifo_we);
    else n_pass++;
  endtask

  task automatic test_full_wr_rd();
    drive(1, 1, 0);
    n_checks++;
    if (bus.fifo_we !== 1'b0)
      $display("FAIL full_wrrd_we: got %b want 0", bus.fifo_we);
    else n_pass++;
    tick("full_wrrd");
    n_checks++;
    if ({bus.fifo_level, bus.fifo_full, bus.fifo_overflow} !== {5'd15, 1'b0, 1'b1})
      $display("FAIL full_wrrd: got lvl=%0d full=%b ovf=%b want 15 0 1",
               bus.fifo_level, bus.fifo_full, bus.fifo_overflow);
    else n_pass++;
    drive(0, 1, 0);
    repeat (15) tick("drain");
    n_checks++;
    if (bus.fifo_empty !== 1'b1 || bus.fifo_underflow !== 1'b0)
      $display("FAIL drain_empty: got empty=%b unf=%b want 1 0",
               bus.fifo_empty, bus.fifo_underflow);
    else n_pass++;
  endtask

  task automatic test_underflow();
    drive(0, 1, 0);
    tick("underflow");
    n_checks++;
    if (bus.fifo_level !== 5'd0 || bus.fifo_underflow !== 1'b1)
      $display("FAIL underflow: got lvl=%0d unf=%b want 0 1", bus.fifo_level, bus.fifo_underflow);
    else n_pass++;
    // Read rejected while empty, write accepted.
    drive(1, 1, 0);
    n_checks++;
    if (bus.fifo_we !== 1'b1)
      $display("FAIL empty_wrrd_we: got %b want 1", bus.fifo_we);
    else n_pass++;
    tick("empty_wrrd");
    drive(0, 0, 1);
    tick("clr_err");
    n_checks++;
    if (bus.fifo_underflow !== 1'b0 || bus.fifo_overflow !== 1'b0)
      $display("FAIL clr_err: got ovf=%b unf=%b want 0 0", bus.fifo_overflow, bus.fifo_underflow);
    else n_pass++;
    drive(0, 1, 0);
    tick("read_last");
    tick("underflow2");
    // Clear and a fresh error in the same cycle: the set wins.
    drive(0, 1, 1);
    tick("clr_vs_set");
    n_checks++;
    if (bus.fifo_underflow !== 1'b1)
      $display("FAIL clr_vs_set: got unf=%b want 1", bus.fifo_underflow);
    else n_pass++;
    drive(0, 0, 1);
    tick("clr_err2");
    drive(0, 0, 0);
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 0);
    repeat (8) tick("to_8");
    drive(1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      tick("b2b");
      n_checks++;
      if (bus.fifo_level !== 5'd8 || bus.fifo_almost_full !== 1'b0 || bus.fifo_almost_empty !== 1'b0)
        $display("FAIL b2b_hold step %0d: got lvl=%0d af=%b ae=%b want 8 0 0",
                 i, bus.fifo_level, bus.fifo_almost_full, bus.fifo_almost_empty);
      else n_pass++;
    end
    drive(0, 0, 0);
  endtask

  task automatic test_ptr_check();
`ifdef FIFO_PTR_CHECK_EN
    tick("pc_idle");
    m_wptr   = m_wptr + 1'b1;
    bus.wptr = m_wptr;
    tick("pc_bump");
    n_checks++;
    if (bus.ptr_mismatch !== 1'b1)
      $display("FAIL ptr_mismatch_set: got %b want 1", bus.ptr_mismatch);
    else n_pass++;
    m_wptr   = m_wptr - 1'b1;
    bus.wptr = m_wptr;
    tick("pc_sticky");
    drive(0, 0, 1);
    tick("pc_clr");
    n_checks++;
    if (bus.ptr_mismatch !== 1'b0)
      $display("FAIL ptr_mismatch_clr: got %b want 0", bus.ptr_mismatch);
    else n_pass++;
    drive(0, 0, 0);
`endif
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    drive(1, 0, 0);
    tick("mid_reset");
    rst = 1'b0;
    drive(0, 0, 0);
    n_checks++;
    if (bus.fifo_level !== 5'd0 || bus.fifo_empty !== 1'b1)
      $display("FAIL mid_reset: got lvl=%0d empty=%b want 0 1", bus.fifo_level, bus.fifo_empty);
    else n_pass++;
    tick("post_reset");
  endtask

  initial begin
    cycle = 0; n_checks = 0; n_pass = 0;
    m_level = 0; m_ovf = 0; m_unf = 0; m_mm = 0; m_wptr = '0; m_rptr = '0;
    rst = 1'b1;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.clr_err = 1'b0;
    bus.wptr = '0; bus.rptr = '0;
    test_reset();
    test_fill();
    test_full_wr_rd();
    test_underflow();
    test_back_to_back();
    test_ptr_check();
    test_mid_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0)
      $display("FAIL sb_drain: got %0d pending entries want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_status.md
Name: fifo_status

Overview:
Flag and occupancy stage for the 16-entry audio sample FIFO.
- Sits beside the write- and read-pointer stages.
- Consumes raw wr/rd requests and the current 5-bit write and read pointers (4 address bits plus 1 wrap bit).
- Produces qualified fifo_we, registered full/empty, almost flags, level count and sticky overflow/underflow error flags.
- Its fifo_empty output feeds the read-pointer stage; its fifo_we drives the write-pointer stage.

Parameters:
ADDR_W, 4, address bits; depth = 2**ADDR_W = 16, pointer width = ADDR_W+1
AF_LEVEL, 12, fifo_almost_full asserted when level >= AF_LEVEL
AE_LEVEL, 4, fifo_almost_empty asserted when level <= AE_LEVEL

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
wr  in  1  write request from producer (audio sample in)
rd  in  1  read request from consumer
wptr  in  ADDR_W+1  current write pointer
rptr  in  ADDR_W+1  current read pointer
clr_err  in  1  clears sticky error flags
fifo_we  out  1  qualified write enable = wr & ~fifo_full (combinational)
fifo_full  out  1  registered full flag
fifo_empty  out  1  registered empty flag
fifo_almost_full  out  1  registered
fifo_almost_empty  out  1  registered
fifo_level  out  ADDR_W+1  registered occupancy, range 0..16
fifo_overflow  out  1  sticky: write attempted while full
fifo_underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (synchronous, rst=1 at the clock edge):
  - fifo_level=0, fifo_empty=1, fifo_full=0, fifo_almost_empty=1, fifo_almost_full=0, fifo_overflow=0, fifo_underflow=0.
  - Reset takes priority over every other input.
  - Mid-operation reset discards the level; the pointer stages are reset by the same rst.
- Qualification (combinational):
  - we_q = wr & ~fifo_full
  - rd_q = rd & ~fifo_empty
  - fifo_we = we_q
- Level update each cycle:
  - we_q & ~rd_q: +1
  - rd_q & ~we_q: -1
  - both or neither: hold
- Simultaneous requests:
  - When full, wr is rejected even if rd is also accepted that cycle; level goes 16 -> 15.
  - When empty, rd is rejected and wr is accepted; level goes 0 -> 1.
  - Neither case sets an error flag unless the rejected request fits the sticky-flag rules below.
- Flags are registered from the next level, so they track the level with zero lag:
  - full = (next level == 16)
  - empty = (next level == 0)
  - almost_full = (next level >= AF_LEVEL)
  - almost_empty = (next level <= AE_LEVEL)
- Flags are never derived combinationally from the pointers.
- Level arithmetic is ADDR_W+1 bits wide; by construction it never wraps.
- Sticky errors:
  - fifo_overflow sets when wr & fifo_full.
  - fifo_underflow sets when rd & fifo_empty.
  - Both hold until clr_err=1 or rst.
  - If clr_err and a new error event occur in the same cycle, the set wins and the flag stays 1.
- Latency: one cycle from an accepted request to the updated level/flags.

Optional Feature:
Macro: FIFO_PTR_CHECK_EN
- Defined:
  - Adds output ptr_mismatch (1 bit, sticky, cleared by clr_err/rst).
  - Each cycle the block computes (wptr - rptr) modulo 2**(ADDR_W+1) and compares it with fifo_level.
  - Any difference sets ptr_mismatch one cycle later.
  - Purpose: catches a pointer stage that advanced without a qualified enable.
- Not defined: no port and no comparison logic; wptr/rptr inputs are unused apart from lint waivers.

Decomposition:
- Shared package fifo_pkg holds:
  - ADDR_W default
  - DEPTH = 2**ADDR_W
  - PTR_W = ADDR_W+1
  - ptr_t and level_t typedefs
  - default AF_LEVEL/AE_LEVEL constants
- The write-pointer, read-pointer and status stages all import it.
- No sub-module: level counter and threshold compares stay in one module.

Test Plan:
- Reset then idle 5 cycles -> level=0, empty=1, almost_empty=1, full=0, errors=0.
- 16 consecutive writes, no reads -> level steps 1..16; almost_full rises on the cycle level reaches 12; full=1 when level=16; fifo_we=0 after that.
- Full, then assert wr and rd together -> fifo_we=0, level 16->15, full=0, overflow=1.
- Empty, then assert rd -> level stays 0, underflow=1; pulse clr_err -> underflow=0 next cycle.
- Level 8, wr and rd together for 10 cycles -> level holds at 8, no flag changes.
- With FIFO_PTR_CHECK_EN, force wptr +1 with no wr -> ptr_mismatch=1 one cycle later; clr_err clears it.
